multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the RV32I subset core: lw, sw, R-type, I-type ALU, jal, beq, bne.
- Sequences the shared-memory datapath (PC, IR, OldPC, ALUOut, Data registers; one memory port) one instruction at a time.
- Replaces the combinational main/ALU decoder pair with a state machine, and adds a memory wait-state handshake.

---
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I subset core (lw, sw, R-type, I-type ALU,
// jal, beq, bne). Sequences the shared-memory datapath one instruction at a
// time and stalls on the memory handshake in FETCH, MEMREAD and MEMWRITE.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation class chosen by the state; 10 defers to funct3/funct7
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_DECODE = 2'b10;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;
    logic       mem_req_raw;
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    // Only funct7[5] matters for this subset
    logic       unused_funct7_bits;
    assign unused_funct7_bits = ^{funct7[6], funct7[4:0]};

    // State register; reset aborts any instruction and returns to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; memory/branch strobes gated here
    always_comb begin
        state_d       = state_q;
        alu_op        = ALUOP_ADD;
        mem_req_raw   = 1'b0;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;

        case (state_q)
            FETCH: begin
                mem_req_raw  = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_JAL:            state_d = JAL;
                    OP_BRANCH:         state_d = BRANCH;
                    default: begin
                        state_d     = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc      = 1'b1;
                mem_req_raw = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_req_raw   = 1'b1;
                mem_write_raw = mem_ready;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_DECODE;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_DECODE;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = ALUWB;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                state_d = FETCH;
                case (funct3)
                    3'b000:  pc_write_raw = zero;
                    3'b001:  pc_write_raw = ~zero;
                    default: illegal_raw  = 1'b1;
                endcase
            end
            default: begin
                state_d     = FETCH;
                illegal_raw = 1'b1;
            end
        endcase
    end

    // ALU control from the operation class and instruction fields
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            ALUOP_SUB: ALUControl = 3'b001;
            ALUOP_DECODE: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // Strobes are masked by rst_n so nothing is issued while reset is held
    assign mem_req  = rst_n & mem_req_raw;
    assign PCWrite  = rst_n & pc_write_raw;
    assign IRWrite  = rst_n & ir_write_raw;
    assign MemWrite = rst_n & mem_write_raw;
    assign RegWrite = rst_n & reg_write_raw;
    assign illegal  = rst_n & illegal_raw;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected output
// vector for each cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;
    logic [3:0] state;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
    //  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal}
    logic [21:0] actual;
    assign actual = {state, mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: one expected vector per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (actual !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                         e.name, actual, e.v, actual[21:18], e.v[21:18]);
            end
        end
    end

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z);
        op = o; funct3 = f3; funct7 = f7; zero = z;
    endtask

    // Push one expected vector, then advance to just after the next edge
    task automatic ex(input string n, input logic [3:0] st, input logic req,
                      input logic pcw, input logic adr, input logic irw,
                      input logic mw, input logic rw, input logic [1:0] rs,
                      input logic [1:0] sa, input logic [1:0] sb,
                      input logic [1:0] imm, input logic [2:0] alu,
                      input logic ill);
        exp_t e;
        e.name = n;
        e.v = {st, req, pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, ill};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string n, input logic rdy, input logic [1:0] imm);
        mem_ready = rdy;
        ex(n, 4'd0, 1'b1, rdy, 1'b0, rdy, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
    endtask

    task automatic decode(input string n, input logic [1:0] imm, input logic ill);
        ex(n, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill);
    endtask

    task automatic alu_instr(input string n, input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [3:0] exp_st,
                             input logic [1:0] exp_sb, input logic [2:0] exp_alu);
        set_instr(o, f3, f7, 1'b0);
        fetch({n, "_fetch"}, 1'b1, 2'b00);
        decode({n, "_decode"}, 2'b00, 1'b0);
        ex({n, "_exec"}, exp_st, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, exp_sb, 2'b00, exp_alu, 0);
        ex({n, "_wb"}, 4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endtask

    task automatic branch_instr(input string n, input logic [2:0] f3, input logic z,
                                input logic exp_pcw, input logic exp_ill);
        set_instr(BR, f3, 7'd0, z);
        fetch({n, "_fetch"}, 1'b1, 2'b10);
        decode({n, "_decode"}, 2'b10, 1'b0);
        ex({n, "_branch"}, 4'd10, 0, exp_pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, exp_ill);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        set_instr(LW, 3'b010, 7'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // Held in reset: FETCH values with every strobe masked
        ex("reset", 4'd0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);

        // sw interrupted by reset while waiting in MEMWRITE
        rst_n = 1'b1;
        set_instr(SW, 3'b010, 7'd0, 1'b0);
        fetch("rst_sw_fetch", 1'b1, 2'b01);
        decode("rst_sw_decode", 2'b01, 1'b0);
        ex("rst_sw_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
        mem_ready = 1'b0;
        ex("rst_sw_wait", 4'd5, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        ex("rst_mid_write", 4'd0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
        rst_n = 1'b1;

        // lw, with one MEMREAD wait; state 0,1,2,3,(3),4
        set_instr(LW, 3'b010, 7'd0, 1'b0);
        fetch("lw_fetch_after_rst", 1'b1, 2'b00);
        decode("lw_decode", 2'b00, 1'b0);
        ex("lw_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        mem_ready = 1'b0;
        ex("lw_memread_wait", 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        mem_ready = 1'b1;
        ex("lw_memread", 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        ex("lw_memwb", 4'd4, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);

        // sw with two FETCH waits and three MEMWRITE waits
        set_instr(SW, 3'b010, 7'd0, 1'b0);
        fetch("sw_fetch_wait1", 1'b0, 2'b01);
        fetch("sw_fetch_wait2", 1'b0, 2'b01);
        fetch("sw_fetch", 1'b1, 2'b01);
        decode("sw_decode", 2'b01, 1'b0);
        ex("sw_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            ex("sw_wait", 4'd5, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
        mem_ready = 1'b1;
        ex("sw_write", 4'd5, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);

        // ALU decode cases
        alu_instr("r_sub",  RT, 3'b000, 7'b0100000, 4'd6, 2'b00, 3'b001);
        alu_instr("i_addi", IT, 3'b000, 7'b0100000, 4'd7, 2'b01, 3'b000);
        alu_instr("r_add",  RT, 3'b000, 7'b0000000, 4'd6, 2'b00, 3'b000);
        alu_instr("r_slt",  RT, 3'b010, 7'b0000000, 4'd6, 2'b00, 3'b101);
        alu_instr("i_ori",  IT, 3'b110, 7'b0000000, 4'd7, 2'b01, 3'b011);
        alu_instr("r_and",  RT, 3'b111, 7'b0000000, 4'd6, 2'b00, 3'b010);
        alu_instr("r_xor",  RT, 3'b100, 7'b0000000, 4'd6, 2'b00, 3'b000);

        // Branches
        branch_instr("beq_taken",   3'b000, 1'b1, 1'b1, 1'b0);
        branch_instr("beq_not",     3'b000, 1'b0, 1'b0, 1'b0);
        branch_instr("bne_taken",   3'b001, 1'b0, 1'b1, 1'b0);
        branch_instr("bne_not",     3'b001, 1'b1, 1'b0, 1'b0);
        branch_instr("blt_illegal", 3'b100, 1'b1, 1'b0, 1'b1);

        // jal with mem_ready low outside FETCH (must be ignored)
        set_instr(JL, 3'b000, 7'd0, 1'b0);
        fetch("jal_fetch", 1'b1, 2'b11);
        mem_ready = 1'b0;
        decode("jal_decode", 2'b11, 1'b0);
        ex("jal_jal", 4'd9, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
        ex("jal_wb", 4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0);

        // Unsupported opcode
        set_instr(BAD, 3'b000, 7'd0, 1'b0);
        fetch("bad_fetch", 1'b1, 2'b00);
        decode("bad_decode", 2'b00, 1'b1);
        fetch("bad_next_fetch", 1'b1, 2'b00);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
